// File: rtl/csi2_pkt_parser_if.sv
// rtl/csi2_pkt_parser_if.sv - byte stream into and payload stream out of the CSI-2 packet parser
interface csi2_pkt_parser_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_sot;
  logic       s_eot;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_sol;
  logic       m_eol;

  modport master (
    output s_valid, s_data, s_sot, s_eot,
    input  m_valid, m_data, m_sol, m_eol
  );

  modport slave (
    input  s_valid, s_data, s_sot, s_eot,
    output m_valid, m_data, m_sol, m_eol
  );
endinterface

// File: rtl/csi2_pkt_parser.sv
// rtl/csi2_pkt_parser.sv - CSI-2 header decode, payload forwarding, FS/FE and line/frame counting; payload CRC check when CSI2_CRC_CHECK_EN is defined
module csi2_pkt_parser #(
  parameter logic [1:0]  VC_ID  = 2'd0,
  parameter logic [15:0] MAX_WC = 16'd8192
) (
  input  logic               clk_50m,
  input  logic               rst,
  csi2_pkt_parser_if.slave   bus,
  output logic [5:0]         dt,
  output logic [15:0]        wc,
  output logic               fs_pulse,
  output logic               fe_pulse,
  output logic [15:0]        line_cnt,
  output logic [15:0]        frame_cnt,
  output logic               err_len,
  output logic               err_crc
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] HDR_WC0  = 3'd1;
  localparam logic [2:0] HDR_WC1  = 3'd2;
  localparam logic [2:0] HDR_ECC  = 3'd3;
  localparam logic [2:0] PAYLOAD  = 3'd4;
  localparam logic [2:0] CRC0     = 3'd5;
  localparam logic [2:0] CRC1     = 3'd6;
  localparam logic [2:0] WAIT_EOT = 3'd7;

  logic [2:0]  state_q;
  logic [7:0]  di_q;
  logic [15:0] wc_q;
  logic [15:0] cnt_q;
  logic        sol_q;
  logic        m_valid_q;
  logic [7:0]  m_data_q;
  logic        m_sol_q;
  logic        m_eol_q;

  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_sol   = m_sol_q;
  assign bus.m_eol   = m_eol_q;

  // Packet FSM: one accepted byte per cycle; pulses clear every cycle unless re-asserted.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q   <= IDLE;
      di_q      <= 8'd0;
      wc_q      <= 16'd0;
      cnt_q     <= 16'd0;
      sol_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= 8'd0;
      m_sol_q   <= 1'b0;
      m_eol_q   <= 1'b0;
      dt        <= 6'd0;
      wc        <= 16'd0;
      fs_pulse  <= 1'b0;
      fe_pulse  <= 1'b0;
      line_cnt  <= 16'd0;
      frame_cnt <= 16'd0;
      err_len   <= 1'b0;
    end else begin
      m_valid_q <= 1'b0;
      m_sol_q   <= 1'b0;
      m_eol_q   <= 1'b0;
      fs_pulse  <= 1'b0;
      fe_pulse  <= 1'b0;
      err_len   <= 1'b0;
      if (bus.s_valid) begin
        if (bus.s_sot) begin
          // A new burst always restarts header capture; abandoning a live packet is an error.
          err_len <= (state_q != IDLE) && (state_q != WAIT_EOT);
          di_q    <= bus.s_data;
          state_q <= HDR_WC0;
        end else begin
          case (state_q)
            HDR_WC0: begin
              wc_q[7:0] <= bus.s_data;
              if (bus.s_eot) begin
                err_len <= 1'b1;
                state_q <= IDLE;
              end else begin
                state_q <= HDR_WC1;
              end
            end
            HDR_WC1: begin
              wc_q[15:8] <= bus.s_data;
              if (bus.s_eot) begin
                err_len <= 1'b1;
                state_q <= IDLE;
              end else begin
                state_q <= HDR_ECC;
              end
            end
            HDR_ECC: begin
              if (di_q[7:6] != VC_ID) begin
                state_q <= bus.s_eot ? IDLE : WAIT_EOT;
              end else if (di_q[5:0] < 6'h10) begin
                if (di_q[5:0] == 6'h00) begin
                  fs_pulse <= 1'b1;
                  line_cnt <= 16'd0;
                end
                if (di_q[5:0] == 6'h01) begin
                  fe_pulse  <= 1'b1;
                  frame_cnt <= frame_cnt + 16'd1;
                end
                state_q <= bus.s_eot ? IDLE : WAIT_EOT;
              end else begin
                dt    <= di_q[5:0];
                wc    <= wc_q;
                cnt_q <= wc_q;
                sol_q <= 1'b1;
                if (wc_q > MAX_WC) begin
                  err_len <= 1'b1;
                  state_q <= bus.s_eot ? IDLE : WAIT_EOT;
                end else if (bus.s_eot) begin
                  // Long packet ended before its payload/footer arrived.
                  err_len <= 1'b1;
                  state_q <= IDLE;
                end else begin
                  state_q <= (wc_q == 16'd0) ? CRC0 : PAYLOAD;
                end
              end
            end
            PAYLOAD: begin
              m_valid_q <= 1'b1;
              m_data_q  <= bus.s_data;
              m_sol_q   <= sol_q;
              sol_q     <= 1'b0;
              cnt_q     <= cnt_q - 16'd1;
              if (bus.s_eot) begin
                // Truncated line: the byte is still forwarded but never marked as end of line.
                err_len <= 1'b1;
                state_q <= IDLE;
              end else if (cnt_q == 16'd1) begin
                m_eol_q  <= 1'b1;
                line_cnt <= line_cnt + 16'd1;
                state_q  <= CRC0;
              end
            end
            CRC0: begin
              if (bus.s_eot) begin
                err_len <= 1'b1;
                state_q <= IDLE;
              end else begin
                state_q <= CRC1;
              end
            end
            CRC1:     state_q <= bus.s_eot ? IDLE : WAIT_EOT;
            WAIT_EOT: if (bus.s_eot) state_q <= IDLE;
            default:  state_q <= IDLE;
          endcase
        end
      end
    end
  end

`ifdef CSI2_CRC_CHECK_EN
  logic [15:0] crc_q;
  logic [7:0]  crc_lo_q;
  logic        err_crc_q;

  // CRC-16 x^16+x^12+x^5+1 in reflected form, so data bits enter LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'h8408;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Payload CRC: reseeded on every header, accumulated over payload, compared on the second footer byte.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      crc_q     <= 16'hFFFF;
      crc_lo_q  <= 8'd0;
      err_crc_q <= 1'b0;
    end else begin
      err_crc_q <= 1'b0;
      if (bus.s_valid && !bus.s_sot) begin
        case (state_q)
          HDR_ECC: crc_q     <= 16'hFFFF;
          PAYLOAD: crc_q     <= crc16_byte(crc_q, bus.s_data);
          CRC0:    crc_lo_q  <= bus.s_data;
          CRC1:    err_crc_q <= (crc_q != {bus.s_data, crc_lo_q});
          default: ;
        endcase
      end
    end
  end

  assign err_crc = err_crc_q;
`else
  assign err_crc = 1'b0;
`endif

endmodule

// File: tb/tb_csi2_pkt_parser.sv
// tb/tb_csi2_pkt_parser.sv - self-checking bench for csi2_pkt_parser
module tb_csi2_pkt_parser;
  localparam logic [15:0] MAX_WC = 16'd8192;
`ifdef CSI2_CRC_CHECK_EN
  localparam int CRC_ON = 1;
`else
  localparam int CRC_ON = 0;
`endif

  typedef struct {
    logic [7:0]  di;
    logic [15:0] wc;
    int          nsend;
    bit          bad;
    int          e_mv;
    int          e_eol;
    int          e_fs;
    int          e_fe;
    int          e_len;
    int          e_crc;
  } vec_t;

  logic        clk_50m = 1'b0;
  logic        rst;
  logic [5:0]  dt;
  logic [15:0] wc;
  logic        fs_pulse;
  logic        fe_pulse;
  logic [15:0] line_cnt;
  logic [15:0] frame_cnt;
  logic        err_len;
  logic        err_crc;

  csi2_pkt_parser_if bus ();

  csi2_pkt_parser #(.VC_ID(2'd0), .MAX_WC(MAX_WC)) dut (
    .clk_50m   (clk_50m),
    .rst       (rst),
    .bus       (bus),
    .dt        (dt),
    .wc        (wc),
    .fs_pulse  (fs_pulse),
    .fe_pulse  (fe_pulse),
    .line_cnt  (line_cnt),
    .frame_cnt (frame_cnt),
    .err_len   (err_len),
    .err_crc   (err_crc)
  );

  always #10 clk_50m = ~clk_50m;

  int n_pass = 0;
  int n_total = 0;
  logic [9:0] act_q[$];
  int fs_n, fe_n, len_n, crc_n;
  logic [7:0] tx_q[$];
  logic [7:0] pay_q[$];
  logic [15:0] exp_line, exp_frame, exp_wc;
  logic [5:0]  exp_dt;
  vec_t tbl[15];

  // Monitor: record forwarded bytes and count pulse cycles.
  always @(negedge clk_50m) begin
    if (bus.m_valid) act_q.push_back({bus.m_sol, bus.m_eol, bus.m_data});
    if (fs_pulse) fs_n++;
    if (fe_pulse) fe_n++;
    if (err_len)  len_n++;
    if (err_crc)  crc_n++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic sot, input logic eot);
    bus.s_valid = v;
    bus.s_data  = d;
    bus.s_sot   = sot;
    bus.s_eot   = eot;
    @(negedge clk_50m);
  endtask

  task automatic build(input logic [7:0] di, input logic [15:0] w, input bit bad, input bit rnd);
    logic [15:0] c;
    int n;
    tx_q.delete();
    pay_q.delete();
    tx_q.push_back(di);
    tx_q.push_back(w[7:0]);
    tx_q.push_back(w[15:8]);
    tx_q.push_back(8'h3C);
    if (di[5:0] >= 6'h10) begin
      n = (w > MAX_WC) ? 2 : int'(w);
      for (int i = 0; i < n; i++) pay_q.push_back(rnd ? 8'($urandom) : 8'(8'h11 * (i + 1)));
      c = 16'hFFFF;
      foreach (pay_q[i]) begin
        for (int k = 0; k < 8; k++) begin
          c = c ^ {15'd0, pay_q[i][k]};
          c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
      end
      if (bad) c = c ^ 16'h0001;
      foreach (pay_q[i]) tx_q.push_back(pay_q[i]);
      tx_q.push_back(c[7:0]);
      tx_q.push_back(c[15:8]);
    end
  endtask

  function automatic vec_t model(input vec_t vi);
    vec_t v;
    int n;
    int w;
    v = vi;
    n = v.nsend;
    w = int'(v.wc);
    v.e_mv = 0; v.e_eol = 0; v.e_fs = 0; v.e_fe = 0; v.e_len = 0; v.e_crc = 0;
    if (n < 4) v.e_len = 1;
    else if (v.di[7:6] != 2'd0) v.e_len = 0;
    else if (v.di[5:0] < 6'h10) begin
      v.e_fs = int'(v.di[5:0] == 6'h00);
      v.e_fe = int'(v.di[5:0] == 6'h01);
    end else if (v.wc > MAX_WC) v.e_len = 1;
    else begin
      v.e_mv  = (n - 4 < w) ? n - 4 : w;
      v.e_eol = int'(w != 0 && n >= w + 5);
      v.e_len = int'(n < w + 6);
      v.e_crc = int'(CRC_ON == 1 && v.bad && n == w + 6);
    end
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input bit gaps);
    int a0, f0, e0, l0, c0, nsend;
    build(v.di, v.wc, v.bad, gaps);
    nsend = (v.nsend == 0) ? tx_q.size() : v.nsend;
    a0 = act_q.size(); f0 = fs_n; e0 = fe_n; l0 = len_n; c0 = crc_n;
    for (int i = 0; i < nsend; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) drive(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
      drive(1'b1, tx_q[i], i == 0, i == nsend - 1);
    end
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    if (nsend >= 4 && v.di[7:6] == 2'd0 && v.di[5:0] >= 6'h10) begin
      exp_dt = v.di[5:0];
      exp_wc = v.wc;
    end
    if (v.e_fs != 0) exp_line = 16'd0;
    if (v.e_fe != 0) exp_frame = exp_frame + 16'd1;
    exp_line = exp_line + 16'(v.e_eol);
    chk("mv_count", act_q.size() - a0, v.e_mv);
    for (int j = 0; j < v.e_mv && a0 + j < act_q.size(); j++)
      chk("pay_byte", act_q[a0 + j], {j == 0, v.e_eol != 0 && j == v.e_mv - 1, pay_q[j]});
    chk("fs_count", fs_n - f0, v.e_fs);
    chk("fe_count", fe_n - e0, v.e_fe);
    chk("err_len_count", len_n - l0, v.e_len);
    chk("err_crc_count", crc_n - c0, v.e_crc);
    chk("line_cnt", line_cnt, exp_line);
    chk("frame_cnt", frame_cnt, exp_frame);
    chk("dt", dt, exp_dt);
    chk("wc", wc, exp_wc);
  endtask

  initial begin
    vec_t v;
    int k;
    int a0, l0;
    logic [15:0] c;
    tbl[0]  = '{8'h2A, 16'd4,      0, 1'b0, 4, 1, 0, 0, 0, 0};
    tbl[1]  = '{8'h2A, 16'd4,      0, 1'b1, 4, 1, 0, 0, 0, CRC_ON};
    tbl[2]  = '{8'h00, 16'd0,      0, 1'b0, 0, 0, 1, 0, 0, 0};
    tbl[3]  = '{8'h6A, 16'd4,      0, 1'b0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{8'h01, 16'd0,      0, 1'b0, 0, 0, 0, 1, 0, 0};
    tbl[5]  = '{8'h2A, 16'd4,      6, 1'b0, 2, 0, 0, 0, 1, 0};
    tbl[6]  = '{8'h00, 16'd0,      0, 1'b0, 0, 0, 1, 0, 0, 0};
    tbl[7]  = '{8'h2B, 16'h2001,   6, 1'b0, 0, 0, 0, 0, 1, 0};
    tbl[8]  = '{8'h2A, 16'd0,      0, 1'b0, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{8'h2A, 16'd1,      0, 1'b0, 1, 1, 0, 0, 0, 0};
    tbl[10] = '{8'h08, 16'd0,      0, 1'b0, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{8'h2A, 16'd4,      4, 1'b0, 0, 0, 0, 0, 1, 0};
    tbl[12] = '{8'h2C, 16'd3,      8, 1'b0, 3, 1, 0, 0, 1, 0};
    tbl[13] = '{8'h2A, 16'd4,      3, 1'b0, 0, 0, 0, 0, 1, 0};
    tbl[14] = '{8'h01, 16'd0,      0, 1'b0, 0, 0, 0, 1, 0, 0};

    rst = 1'b1;
    bus.s_valid = 1'b0; bus.s_data = 8'd0; bus.s_sot = 1'b0; bus.s_eot = 1'b0;
    repeat (3) @(negedge clk_50m);
    rst = 1'b0;
    @(negedge clk_50m);
    chk("reset_outs", {bus.m_valid, bus.m_data, bus.m_sol, bus.m_eol, fs_pulse, fe_pulse, err_len, err_crc, dt}, 32'd0);
    chk("reset_cnts", {line_cnt, frame_cnt}, 32'd0);
    chk("reset_wc", wc, 32'd0);

    // FS: pulse exactly one cycle after the ECC byte.
    drive(1'b1, 8'h00, 1'b1, 1'b0);
    drive(1'b1, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'h5A, 1'b0, 1'b1);
    chk("fs_pulse_on", fs_pulse, 1);
    chk("fs_no_mvalid", bus.m_valid, 0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("fs_pulse_off", fs_pulse, 0);
    chk("fs_line_cnt", line_cnt, 0);

    // Long packet, cycle-accurate forwarding, then same packet with a corrupted footer.
    for (int p = 0; p < 2; p++) begin
      build(8'h2A, 16'd4, p == 1, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b1, tx_q[i], i == 0, 1'b0);
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, tx_q[4 + i], 1'b0, 1'b0);
        chk("lp_mvalid", bus.m_valid, 1);
        chk("lp_mdata", bus.m_data, tx_q[4 + i]);
        chk("lp_sol_eol", {bus.m_sol, bus.m_eol}, {i == 0, i == 3});
      end
      drive(1'b1, tx_q[8], 1'b0, 1'b0);
      chk("lp_crc0_quiet", bus.m_valid, 0);
      drive(1'b1, tx_q[9], 1'b0, 1'b1);
      chk("lp_err_crc", err_crc, (p == 1) ? CRC_ON : 0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk("lp_err_crc_off", err_crc, 0);
      chk("lp_dt_wc", {dt, wc}, {6'h2A, 16'd4});
      chk("lp_line_cnt", line_cnt, p + 1);
    end

    // Reset mid-payload: outputs clear, leftover bytes are ignored.
    build(8'h2A, 16'd4, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, tx_q[i], i == 0, 1'b0);
    rst = 1'b1;
    bus.s_data = tx_q[6];
    @(negedge clk_50m);
    rst = 1'b0;
    chk("rst_mid_outs", {bus.m_valid, bus.m_sol, bus.m_eol, fs_pulse, fe_pulse, err_len, err_crc, dt}, 32'd0);
    chk("rst_mid_cnts", {line_cnt, frame_cnt}, 32'd0);
    chk("rst_mid_wc", wc, 0);
    a0 = act_q.size(); l0 = len_n;
    drive(1'b1, tx_q[7], 1'b0, 1'b0);
    drive(1'b1, tx_q[8], 1'b0, 1'b0);
    drive(1'b1, tx_q[9], 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_leftover_mv", act_q.size() - a0, 0);
    chk("rst_leftover_err", len_n - l0, 0);

    // New SOT inside a payload aborts it with err_len and decodes the new header.
    build(8'h2A, 16'd4, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, tx_q[i], i == 0, 1'b0);
    chk("sot_pre_mvalid", bus.m_valid, 1);
    drive(1'b1, 8'h00, 1'b1, 1'b0);
    chk("sot_err_len", err_len, 1);
    drive(1'b1, 8'h00, 1'b0, 1'b0);
    chk("sot_err_len_off", err_len, 0);
    drive(1'b1, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'h77, 1'b0, 1'b1);
    chk("sot_fs_pulse", fs_pulse, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    exp_dt = 6'h2A; exp_wc = 16'd4; exp_line = 16'd0; exp_frame = 16'd0;

    for (int t = 0; t < 15; t++) run_vec(tbl[t], 1'b0);

    for (int r = 0; r < 150; r++) begin
      v = '{default: 0};
      k = $urandom_range(0, 7);
      case (k)
        0: v.di = 8'h00;
        1: v.di = 8'h01;
        2: v.di = 8'($urandom_range(2, 15));
        5: begin
          v.di = {2'($urandom_range(1, 3)), 6'($urandom)};
          v.wc = 16'($urandom_range(0, 20));
        end
        7: v.di = {2'b00, 6'($urandom_range(16, 63))};
        default: begin
          v.di  = {2'b00, 6'($urandom_range(16, 63))};
          v.wc  = 16'($urandom_range((k == 6) ? 1 : 0, 20));
          v.bad = (k == 4);
        end
      endcase
      if (k == 7) begin
        v.wc = MAX_WC + 16'($urandom_range(1, 200));
        v.nsend = $urandom_range(4, 8);
      end else if (k == 6) v.nsend = $urandom_range(2, int'(v.wc) + 5);
      else v.nsend = (v.di[5:0] < 6'h10) ? 4 : int'(v.wc) + 6;
      v = model(v);
      run_vec(v, 1'b1);
      for (int j = $urandom_range(0, 2); j > 0; j--) drive(1'b1, 8'($urandom), 1'b0, 1'($urandom));
    end

    c = 16'(n_total);
    if (c == 16'd0) $display("FAIL no_checks: got 0 expected >0");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
